// File: rtl/lstm_acc_if.sv
// Handshake bundle between the adder tree, the row accumulator and the activation stage.
// The source side drives beats in and accepts results; the accumulator side is the slave.
interface lstm_acc_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             i_ready;
   logic [WIDTH-1:0] i_sum;
   logic [WIDTH-1:0] i_bias;
   logic             o_valid;
   logic             o_ready;
   logic [WIDTH-1:0] o_acc;
   logic             o_sat;
   logic             o_busy;

   modport master (
      output i_valid, i_sum, i_bias, o_ready,
      input  i_ready, o_valid, o_acc, o_sat, o_busy
   );

   modport slave (
      input  i_valid, i_sum, i_bias, o_ready,
      output i_ready, o_valid, o_acc, o_sat, o_busy
   );
endinterface

// File: rtl/lstm_acc.sv
// Row accumulator: sums NBEAT adder-tree results plus a bias in a widened register,
// then presents the WIDTH-bit saturated total on a valid/ready handshake.
module lstm_acc #(
   parameter int WIDTH = 32,
   parameter int NBEAT = 4,
   parameter int GUARD = $clog2(NBEAT + 1)
) (
   input  logic        clk,
   input  logic        rst,
   lstm_acc_if.slave   bus
);
   localparam int AW = WIDTH + GUARD;
   localparam int CW = $clog2(NBEAT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NBEAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic [CW-1:0]           cnt_r, cnt_s;
   logic signed [AW-1:0]    acc_r, acc_s;
   logic signed [AW-1:0]    sum_ext_s, bias_ext_s;
   logic [WIDTH-1:0]        o_acc_r;
   logic                    o_sat_r;
   logic                    accept_s, last_s;

   // Returns {clamped, value}: in range when all guard bits plus the top result bit agree.
   function automatic logic [WIDTH:0] saturate(input logic signed [AW-1:0] a);
      logic [WIDTH:0] r;
      if (a[AW-1:WIDTH-1] == {(GUARD + 1){a[AW-1]}}) begin
         r = {1'b0, a[WIDTH-1:0]};
      end else if (a[AW-1]) begin
         r = {1'b1, 1'b1, {(WIDTH - 1){1'b0}}};
      end else begin
         r = {1'b1, 1'b0, {(WIDTH - 1){1'b1}}};
      end
      return r;
   endfunction

   assign sum_ext_s  = {{GUARD{bus.i_sum[WIDTH-1]}}, bus.i_sum};
   assign bias_ext_s = {{GUARD{bus.i_bias[WIDTH-1]}}, bus.i_bias};
   assign accept_s   = bus.i_valid && (state_r != OUT);
   assign last_s     = (cnt_r == LAST_CNT);

   assign bus.i_ready = (state_r != OUT);
   assign bus.o_valid = (state_r == OUT);
   assign bus.o_busy  = (state_r == ACC);
   assign bus.o_acc   = o_acc_r;
   assign bus.o_sat   = o_sat_r;

   // State register together with the beat counter and accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         acc_r   <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         acc_r   <= acc_s;
      end
   end

   // Next-state and accumulate decisions; holding is the default.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      acc_s   = acc_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               acc_s   = bias_ext_s + sum_ext_s;
               cnt_s   = CW'(1);
               state_s = last_s ? OUT : ACC;
            end else begin
               state_s = IDLE;
            end
         end
         ACC: begin
            if (accept_s) begin
               acc_s   = acc_r + sum_ext_s;
               cnt_s   = cnt_r + 1'b1;
               state_s = last_s ? OUT : ACC;
            end else begin
               state_s = ACC;
            end
         end
         OUT: begin
            if (bus.o_ready) begin
               cnt_s   = '0;
               state_s = IDLE;
            end else begin
               state_s = OUT;
            end
         end
         default: begin
            cnt_s   = '0;
            acc_s   = '0;
            state_s = IDLE;
         end
      endcase
   end

   // Result is clamped once, on the transition into OUT, and then held.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_acc_r <= '0;
         o_sat_r <= 1'b0;
      end else if ((state_r != OUT) && (state_s == OUT)) begin
         {o_sat_r, o_acc_r} <= saturate(acc_s);
      end else begin
         o_acc_r <= o_acc_r;
         o_sat_r <= o_sat_r;
      end
   end
endmodule
